// File: rtl/ram_stack_ctrl.sv
// LIFO stack controller that drives a single-port synchronous RAM with push/pop/swap
// commands, a busy handshake, a one-cycle data-valid pulse and sticky error flags.
module ram_stack_ctrl #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 16
) (
    input  logic          cl,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    input  logic          err_clr,
    output logic          busy,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          udf,
    output logic          ram_st,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_x,
    input  logic [DW-1:0] ram_y
);

    localparam int unsigned    SW    = AW + 1;
    localparam logic [SW-1:0]  DEPTH = SW'(2 ** AW);

    typedef enum logic [1:0] {IDLE, WR, RD, CAP} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] sp, sp_nxt;
    logic          swap_op, swap_op_nxt;
    logic [DW-1:0] hold, hold_nxt;
    logic          busy_nxt;
    logic [DW-1:0] dout_nxt;
    logic          dout_valid_nxt;
    logic          ovf_nxt, udf_nxt;
    logic          ovf_set, udf_set;
    logic          ram_st_nxt;
    logic [AW-1:0] ram_ad_nxt;
    logic [DW-1:0] ram_x_nxt;

    assign count = sp;
    assign empty = (sp == '0);
    assign full  = (sp == DEPTH);

    // Register stage: every output and the pointer update only here.
    always_ff @(posedge cl) begin
        if (rst) begin
            state      <= IDLE;
            sp         <= '0;
            swap_op    <= 1'b0;
            hold       <= '0;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
            ram_st     <= 1'b0;
            ram_ad     <= '0;
            ram_x      <= '0;
        end else begin
            state      <= state_nxt;
            sp         <= sp_nxt;
            swap_op    <= swap_op_nxt;
            hold       <= hold_nxt;
            busy       <= busy_nxt;
            dout       <= dout_nxt;
            dout_valid <= dout_valid_nxt;
            ovf        <= ovf_nxt;
            udf        <= udf_nxt;
            ram_st     <= ram_st_nxt;
            ram_ad     <= ram_ad_nxt;
            ram_x      <= ram_x_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt      = state;
        sp_nxt         = sp;
        swap_op_nxt    = swap_op;
        hold_nxt       = hold;
        dout_nxt       = dout;
        dout_valid_nxt = 1'b0;
        ram_st_nxt     = 1'b0;
        ram_ad_nxt     = ram_ad;
        ram_x_nxt      = ram_x;
        ovf_set        = 1'b0;
        udf_set        = 1'b0;

        case (state)
            IDLE: begin
                if (push && !pop) begin
                    if (full) begin
                        ovf_set = 1'b1;
                    end else begin
                        state_nxt   = WR;
                        ram_st_nxt  = 1'b1;
                        ram_ad_nxt  = sp[AW-1:0];
                        ram_x_nxt   = din;
                        swap_op_nxt = 1'b0;
                    end
                end else if (pop) begin
                    if (empty) begin
                        udf_set = 1'b1;
                    end else begin
                        state_nxt   = RD;
                        ram_ad_nxt  = AW'(sp - SW'(1));
                        swap_op_nxt = push;
                        hold_nxt    = din;
                    end
                end
            end
            WR: begin
                state_nxt = IDLE;
                if (!swap_op) sp_nxt = sp + SW'(1);
            end
            RD: begin
                state_nxt = CAP;
            end
            CAP: begin
                dout_nxt       = ram_y;
                dout_valid_nxt = 1'b1;
                // A swap rewrites the same top slot, so ram_ad is left as set in RD.
                if (swap_op) begin
                    state_nxt  = WR;
                    ram_st_nxt = 1'b1;
                    ram_x_nxt  = hold;
                end else begin
                    state_nxt = IDLE;
                    sp_nxt    = sp - SW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
        ovf_nxt  = ovf_set | (ovf & ~err_clr);
        udf_nxt  = udf_set | (udf & ~err_clr);
    end

endmodule

// File: tb/tb_ram_stack_ctrl.sv
// Bench for ram_stack_ctrl: queue-based stack model, RAM model, and a scoreboard monitor
// that checks every dout_valid capture and every RAM store against queued expectations.
module tb_ram_stack_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic          cl = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] din = '0;
    logic          err_clr = 1'b0;
    logic          busy;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          udf;
    logic          ram_st;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_x;
    logic [DW-1:0] ram_y;

    logic [DW-1:0] mem [DEPTH];

    // Reference model state
    logic [DW-1:0]    stk[$];
    logic [DW-1:0]    exp_dout[$];
    logic [AW+DW-1:0] exp_wr[$];
    logic             m_ovf = 1'b0;
    logic             m_udf = 1'b0;
    int               bl = 0;
    int               checks = 0;
    int               fails = 0;

    always #5 cl = ~cl;

    ram_stack_ctrl #(.AW(AW), .DW(DW)) dut (
        .cl(cl), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
        .busy(busy), .dout(dout), .dout_valid(dout_valid), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .udf(udf),
        .ram_st(ram_st), .ram_ad(ram_ad), .ram_x(ram_x), .ram_y(ram_y)
    );

    // Synchronous single-port RAM: read data one cycle after address.
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end
    always @(posedge cl) begin
        if (ram_st === 1'b1) mem[ram_ad] <= ram_x;
        ram_y <= mem[ram_ad];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every capture pulse and every RAM store must match a queued expectation.
    always @(negedge cl) begin
        if (dout_valid !== 1'b0) begin
            if (exp_dout.size() == 0) check("dout_valid_unexpected", 32'(dout_valid), 32'd0);
            else check("dout", 32'(dout), 32'(exp_dout.pop_front()));
        end
        if (ram_st !== 1'b0) begin
            if (exp_wr.size() == 0) check("ram_st_unexpected", 32'(ram_st), 32'd0);
            else check("ram_write", 32'({ram_ad, ram_x}), 32'(exp_wr.pop_front()));
        end
    end

    // One cycle: check idle-state outputs, then drive the command and advance the model.
    task automatic step(input logic p, input logic q, input logic [DW-1:0] d,
                        input logic c, input logic r);
        logic set_o;
        logic set_u;
        @(negedge cl);
        check("busy", 32'(busy), 32'(bl != 0));
        if (bl == 0) begin
            check("count", 32'(count), 32'(stk.size()));
            check("empty", 32'(empty), 32'(stk.size() == 0));
            check("full", 32'(full), 32'(stk.size() == DEPTH));
            check("ovf", 32'(ovf), 32'(m_ovf));
            check("udf", 32'(udf), 32'(m_udf));
        end
        #1;
        push = p; pop = q; din = d; err_clr = c; rst = r;
        set_o = 1'b0;
        set_u = 1'b0;
        if (r) begin
            stk.delete();
            exp_dout.delete();
            exp_wr.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            bl = 0;
        end else begin
            if (bl > 0) begin
                bl--;
            end else if (p && !q) begin
                if (stk.size() == DEPTH) set_o = 1'b1;
                else begin
                    exp_wr.push_back({AW'(stk.size()), d});
                    stk.push_back(d);
                    bl = 1;
                end
            end else if (q) begin
                if (stk.size() == 0) set_u = 1'b1;
                else begin
                    exp_dout.push_back(stk[stk.size()-1]);
                    if (p) begin
                        exp_wr.push_back({AW'(stk.size() - 1), d});
                        stk[stk.size()-1] = d;
                        bl = 3;
                    end else begin
                        void'(stk.pop_back());
                        bl = 2;
                    end
                end
            end
            m_ovf = set_o | (m_ovf & ~c);
            m_udf = set_u | (m_udf & ~c);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Issue a command on the first cycle the model says the controller is idle.
    task automatic cmd(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
        int guard;
        guard = 0;
        while (bl != 0 && guard < 10) begin
            idle();
            guard++;
        end
        step(p, q, d, c, 1'b0);
    endtask

    initial begin
        int unsigned k;
        logic        p, q, c, r;

        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ram_ad", 32'(ram_ad), 32'd0);
        check("rst_ram_x", 32'(ram_x), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_ram_st", 32'(ram_st), 32'd0);

        // Single push, then pop it back
        cmd(1'b1, 1'b0, 16'h1234, 1'b0);
        cmd(1'b0, 1'b0, '0, 1'b0);
        cmd(1'b0, 1'b1, '0, 1'b0);

        // Back-to-back pushes, a dropped command while busy, LIFO pops
        cmd(1'b1, 1'b0, 16'hAAAA, 1'b0);
        cmd(1'b1, 1'b0, 16'hBBBB, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        cmd(1'b0, 1'b1, '0, 1'b0);
        cmd(1'b0, 1'b1, '0, 1'b0);
        cmd(1'b0, 1'b0, '0, 1'b0);

        // Fill, overflow, clear
        for (int i = 0; i < int'(DEPTH); i++) cmd(1'b1, 1'b0, DW'(i), 1'b0);
        cmd(1'b1, 1'b0, 16'hDEAD, 1'b0);
        idle();
        check("ovf_after_full_push", 32'(ovf), 32'd1);
        check("count_full", 32'(count), 32'd16);
        cmd(1'b0, 1'b0, '0, 1'b1);
        idle();
        check("ovf_cleared", 32'(ovf), 32'd0);
        // Swap is legal while full
        cmd(1'b1, 1'b1, 16'h7777, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) cmd(1'b0, 1'b1, '0, 1'b0);

        // Underflow on pop and on swap; set wins over a coincident clear
        cmd(1'b0, 1'b1, '0, 1'b0);
        idle();
        check("udf_pop_empty", 32'(udf), 32'd1);
        cmd(1'b0, 1'b0, '0, 1'b1);
        cmd(1'b1, 1'b1, 16'h4444, 1'b0);
        idle();
        check("udf_swap_empty", 32'(udf), 32'd1);
        cmd(1'b0, 1'b1, '0, 1'b1);
        idle();
        check("udf_set_beats_clear", 32'(udf), 32'd1);
        cmd(1'b0, 1'b0, '0, 1'b1);

        // Swap on a two-deep stack, then pop the swapped-in word
        cmd(1'b1, 1'b0, 16'h0001, 1'b0);
        cmd(1'b1, 1'b0, 16'h0002, 1'b0);
        cmd(1'b1, 1'b1, 16'h0099, 1'b0);
        cmd(1'b0, 1'b0, '0, 1'b0);
        check("count_after_swap", 32'(count), 32'd2);
        cmd(1'b0, 1'b1, '0, 1'b0);
        cmd(1'b0, 1'b1, '0, 1'b0);

        // Reset during a pop's read cycle
        cmd(1'b1, 1'b0, 16'h5555, 1'b0);
        cmd(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        check("abort_dout_valid", 32'(dout_valid), 32'd0);
        check("abort_ram_st", 32'(ram_st), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        cmd(1'b0, 1'b1, '0, 1'b0);
        idle();
        check("udf_after_abort", 32'(udf), 32'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            p = (k < 45) || (k >= 75 && k < 88);
            q = (k >= 45 && k < 88);
            c = ($urandom_range(0, 15) == 0);
            r = (k == 99) && ($urandom_range(0, 3) == 0);
            step(p, q, DW'($urandom), c, r);
        end

        cmd(1'b0, 1'b0, '0, 1'b0);
        idle();
        idle();
        check("dout_queue_drained", 32'(exp_dout.size()), 32'd0);
        check("write_queue_drained", 32'(exp_wr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
